// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: stall, flush, hold, drain/halt and EX forwarding.
// Define HAZARD_PERF_CNT_EN to build the saturating stall/flush/hold performance counters.
module pipeline_hazard_ctrl #(
    parameter int REG_W        = 5,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rs1,
    input  logic [REG_W-1:0] ex_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic             mem_reg_write,
    input  logic             wb_reg_write,
    input  logic [REG_W-1:0] mem_rd,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_branch_taken,
    input  logic             mem_busy,
    input  logic             halt_req,
    output logic             pc_en,
    output logic             pc_sel_branch,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halt_ack,
    output logic [15:0]      stall_cnt,
    output logic [15:0]      flush_cnt,
    output logic [15:0]      hold_cnt
);

    // state  | meaning
    // RUN    | normal issue with stall/flush/hold handling
    // DRAIN  | fetch stopped, NOPs pushed until the back end is empty
    // HALTED | pipeline frozen, halt_ack high until halt_req drops
    typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DCNT_W-1:0] DRAIN_LAST = DCNT_W'(DRAIN_CYCLES - 1);

    state_t            state, state_next;
    logic [DCNT_W-1:0] drain_cnt, drain_cnt_next;
    logic              load_use;

    assign load_use = ex_mem_read && ex_reg_write && (ex_rd != '0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) || (id_use_rs2 && (id_rs2 == ex_rd)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            drain_cnt <= '0;
        end else begin
            state     <= state_next;
            drain_cnt <= drain_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        drain_cnt_next = drain_cnt;
        pc_en          = 1'b1;
        pc_sel_branch  = 1'b0;
        if_id_en       = 1'b1;
        id_ex_en       = 1'b1;
        ex_mem_en      = 1'b1;
        mem_wb_en      = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        halt_ack       = 1'b0;
        case (state)
            RUN: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end else begin
                    // a taken branch squashes the ID instruction, so its load-use hazard is moot
                    if (ex_branch_taken) begin
                        pc_sel_branch = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_bubble  = 1'b1;
                    end else if (load_use) begin
                        pc_en        = 1'b0;
                        if_id_en     = 1'b0;
                        id_ex_bubble = 1'b1;
                    end
                    if (halt_req) begin
                        state_next     = DRAIN;
                        drain_cnt_next = '0;
                    end
                end
            end
            DRAIN: begin
                if (mem_busy) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                    mem_wb_en = 1'b0;
                end else begin
                    // a late branch still loads its target so resume fetches the right path
                    pc_en         = ex_branch_taken;
                    pc_sel_branch = ex_branch_taken;
                    if_id_flush   = 1'b1;
                    if (drain_cnt == DRAIN_LAST) begin
                        state_next = HALTED;
                    end else begin
                        drain_cnt_next = drain_cnt + 1'b1;
                    end
                end
            end
            HALTED: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                halt_ack  = 1'b1;
                if (!halt_req) state_next = RUN;
            end
            default: state_next = RUN;
        endcase
    end

    // EX/MEM result is newer than MEM/WB, so it wins
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs1))     fwd_a = 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs1))   fwd_a = 2'b01;
        if (mem_reg_write && (mem_rd != '0) && (mem_rd == ex_rs2))     fwd_b = 2'b10;
        else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_rs2))   fwd_b = 2'b01;
    end

`ifdef HAZARD_PERF_CNT_EN
    logic stall_evt, flush_evt, hold_evt;

    assign stall_evt = (state == RUN) && !mem_busy && !ex_branch_taken && load_use;
    assign flush_evt = (state == RUN) && !mem_busy && ex_branch_taken;
    assign hold_evt  = (state != HALTED) && mem_busy;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
            hold_cnt  <= '0;
        end else begin
            if (stall_evt && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            if (flush_evt && (flush_cnt != 16'hFFFF)) flush_cnt <= flush_cnt + 16'd1;
            if (hold_evt  && (hold_cnt  != 16'hFFFF)) hold_cnt  <= hold_cnt  + 16'd1;
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign hold_cnt  = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: expected controls are queued per driven cycle and
// compared at the following negedge.
module tb_pipeline_hazard_ctrl;

    localparam int REG_W = 5;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_flush, id_ex_bubble, halt_ack}
    localparam logic [8:0] O_RUN  = 9'b1_0_1111_00_0;
    localparam logic [8:0] O_HOLD = 9'b0_0_0000_00_0;
    localparam logic [8:0] O_FLSH = 9'b1_1_1111_11_0;
    localparam logic [8:0] O_STAL = 9'b0_0_0111_01_0;
    localparam logic [8:0] O_DRN  = 9'b0_0_1111_10_0;
    localparam logic [8:0] O_DRNB = 9'b1_1_1111_10_0;
    localparam logic [8:0] O_HLT  = 9'b0_0_0000_00_1;

    logic clk = 1'b0;
    logic reset;
    logic [REG_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, ex_mem_read, ex_reg_write, mem_reg_write, wb_reg_write;
    logic ex_branch_taken, mem_busy, halt_req;
    logic pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_bubble, halt_ack;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt, hold_cnt;
    logic [8:0] ctl;

    assign ctl = {pc_en, pc_sel_branch, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_bubble, halt_ack};

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(4)) dut (
        .clk(clk), .reset(reset),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
        .ex_reg_write(ex_reg_write), .mem_reg_write(mem_reg_write), .wb_reg_write(wb_reg_write),
        .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_branch_taken(ex_branch_taken),
        .mem_busy(mem_busy), .halt_req(halt_req),
        .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_bubble(id_ex_bubble), .fwd_a(fwd_a), .fwd_b(fwd_b), .halt_ack(halt_ack),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .hold_cnt(hold_cnt)
    );

    typedef struct {
        int          id;
        logic [8:0]  ctl;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [2:0]  cm;     // which counters to compare: {stall, flush, hold}
        logic [15:0] st;
        logic [15:0] fl;
        logic [15:0] hd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc_id   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic logic [15:0] p(input int n);
        return PERF ? 16'(n) : 16'd0;
    endfunction

    task automatic clr();
        id_rs1 = '0; id_rs2 = '0; ex_rs1 = '0; ex_rs2 = '0; ex_rd = '0; mem_rd = '0; wb_rd = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; ex_mem_read = 0; ex_reg_write = 0;
        mem_reg_write = 0; wb_reg_write = 0; ex_branch_taken = 0; mem_busy = 0; halt_req = 0;
    endtask

    task automatic cyc(input logic [8:0] c, input logic [1:0] fa, input logic [1:0] fb,
                       input logic [2:0] cm, input logic [15:0] st, input logic [15:0] fl,
                       input logic [15:0] hd);
        exp_t e;
        e.id = cyc_id; e.ctl = c; e.fa = fa; e.fb = fb; e.cm = cm; e.st = st; e.fl = fl; e.hd = hd;
        exp_q.push_back(e);
        cyc_id++;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check($sformatf("ctl@%0d", e.id), 32'(ctl), 32'(e.ctl));
            check($sformatf("fwd_a@%0d", e.id), 32'(fwd_a), 32'(e.fa));
            check($sformatf("fwd_b@%0d", e.id), 32'(fwd_b), 32'(e.fb));
            if (e.cm[2]) check($sformatf("stall_cnt@%0d", e.id), 32'(stall_cnt), 32'(e.st));
            if (e.cm[1]) check($sformatf("flush_cnt@%0d", e.id), 32'(flush_cnt), 32'(e.fl));
            if (e.cm[0]) check($sformatf("hold_cnt@%0d", e.id), 32'(hold_cnt), 32'(e.hd));
        end
    end

    initial begin
        reset = 1'b1;
        clr();
        #3;
        check("rst_ctl", 32'(ctl), 32'(O_RUN));
        check("rst_fwd", 32'({fwd_a, fwd_b}), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        cyc(O_RUN, 2'b00, 2'b00, 3'b111, 0, 0, 0);

        // load to x5 in EX, ID reads x5: one bubble, then forwarded from EX/MEM
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 5; id_use_rs1 = 1; id_rs1 = 5;
        cyc(O_STAL, 2'b00, 2'b00, 3'b111, 0, 0, 0);
        clr(); mem_reg_write = 1; mem_rd = 5; ex_rs1 = 5;
        cyc(O_RUN, 2'b10, 2'b00, 3'b111, p(1), 0, 0);

        // x0 never stalls or forwards
        clr(); ex_mem_read = 1; ex_reg_write = 1; id_use_rs1 = 1; id_use_rs2 = 1;
        mem_reg_write = 1; wb_reg_write = 1;
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, p(1), 0, 0);

        // taken branch beats a simultaneous load-use on rs2
        clr(); ex_branch_taken = 1; ex_mem_read = 1; ex_reg_write = 1; ex_rd = 9;
        id_use_rs2 = 1; id_rs2 = 9;
        cyc(O_FLSH, 2'b00, 2'b00, 3'b111, p(1), 0, 0);
        clr();
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, p(1), p(1), 0);

        // forwarding priority on operand b
        mem_rd = 7; wb_rd = 7; mem_reg_write = 1; wb_reg_write = 1; ex_rs2 = 7;
        cyc(O_RUN, 2'b00, 2'b10, 3'b111, p(1), p(1), 0);
        mem_reg_write = 0;
        cyc(O_RUN, 2'b00, 2'b01, 3'b111, p(1), p(1), 0);
        ex_rs1 = 7; wb_reg_write = 0;
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, p(1), p(1), 0);

        // mem_busy holds everything, even over a branch
        clr(); mem_busy = 1;
        cyc(O_HOLD, 2'b00, 2'b00, 3'b111, p(1), p(1), 0);
        ex_branch_taken = 1;
        cyc(O_HOLD, 2'b00, 2'b00, 3'b111, p(1), p(1), p(1));
        clr();
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, p(1), p(1), p(2));

        // halt with two hold cycles mid-drain: halt_ack 7 cycles after request
        halt_req = 1;
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, p(1), p(1), p(2));
        cyc(O_DRN, 2'b00, 2'b00, 3'b111, p(1), p(1), p(2));
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 3; id_use_rs1 = 1; id_rs1 = 3;
        cyc(O_DRN, 2'b00, 2'b00, 3'b111, p(1), p(1), p(2));
        ex_mem_read = 0; ex_reg_write = 0; ex_rd = 0; id_use_rs1 = 0; id_rs1 = 0;
        mem_busy = 1;
        cyc(O_HOLD, 2'b00, 2'b00, 3'b101, p(1), 0, p(2));
        cyc(O_HOLD, 2'b00, 2'b00, 3'b101, p(1), 0, p(3));
        mem_busy = 0; ex_branch_taken = 1;
        cyc(O_DRNB, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));
        ex_branch_taken = 0;
        cyc(O_DRN, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));
        cyc(O_HLT, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));
        cyc(O_HLT, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));
        halt_req = 0;
        cyc(O_HLT, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));
        cyc(O_RUN, 2'b00, 2'b00, 3'b101, p(1), 0, p(4));

        // halt_req dropped during drain: full drain, one HALTED cycle, then RUN
        halt_req = 1;
        cyc(O_RUN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        halt_req = 0;
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        ex_rs1 = 4; mem_rd = 4; mem_reg_write = 1;
        cyc(O_HLT, 2'b10, 2'b00, 3'b000, 0, 0, 0);
        clr();
        cyc(O_RUN, 2'b00, 2'b00, 3'b000, 0, 0, 0);

        // asynchronous reset in the middle of a drain
        halt_req = 1;
        cyc(O_RUN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        cyc(O_DRN, 2'b00, 2'b00, 3'b000, 0, 0, 0);
        reset = 1'b1;
        #2;
        check("arst_ctl", 32'(ctl), 32'(O_RUN));
        check("arst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("arst_flush_cnt", 32'(flush_cnt), 32'd0);
        check("arst_hold_cnt", 32'(hold_cnt), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        clr();
        cyc(O_RUN, 2'b00, 2'b00, 3'b111, 0, 0, 0);

`ifdef HAZARD_PERF_CNT_EN
        // held load-use: stall counter must saturate rather than wrap
        ex_mem_read = 1; ex_reg_write = 1; ex_rd = 6; id_use_rs1 = 1; id_rs1 = 6;
        repeat (70000) @(posedge clk);
        #1;
        check("sat_ctl", 32'(ctl), 32'(O_STAL));
        check("sat_stall_cnt", 32'(stall_cnt), 32'hFFFF);
        check("sat_hold_cnt", 32'(hold_cnt), 32'd0);
        clr();
`endif

        repeat (2) @(posedge clk);
        if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage pipeline (IF, IF/ID, ID/EX, EX/MEM, MEM/WB). It generates PC and pipeline-register enables and the bubble/flush controls for load-use stalls, taken branches, data-memory wait states and a halt/drain request. It also produces EX-stage operand-forwarding selects. It sits beside the datapath, takes decoded register fields from each stage and drives the enable/flush inputs of the PC and stage registers.

## Interface
- REG_W, 5, register-index width
- DRAIN_CYCLES, 4, bubble cycles needed to empty ID/EX through MEM/WB after fetch stops
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- id_rs1, id_rs2  in  REG_W each  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads that source
- ex_rs1, ex_rs2  in  REG_W each  source registers in EX (forwarding)
- ex_rd  in  REG_W  EX destination
- ex_mem_read  in  1  EX instruction is a load
- ex_reg_write, mem_reg_write, wb_reg_write  in  1 each  stage writes the register file
- mem_rd, wb_rd  in  REG_W each  MEM and WB destinations
- ex_branch_taken  in  1  branch resolved taken in EX
- mem_busy  in  1  data memory wait state
- halt_req  in  1  level request to drain and halt
- pc_en  out  1  PC update enable
- pc_sel_branch  out  1  PC loads branch target instead of PC+4
- if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  stage-register enables
- if_id_flush, id_ex_bubble  out  1 each  load NOP into IF/ID and ID/EX
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB
- halt_ack  out  1  pipeline drained and halted
- stall_cnt, flush_cnt, hold_cnt  out  16 each  performance counters

## Operation
- State register: RUN, DRAIN, HALTED. Outputs are Mealy: combinational from state and inputs.
- A hazard match requires a nonzero rd; register 0 never causes a stall or a forward.
- Load-use condition: ex_mem_read & ex_reg_write & ex_rd≠0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN, highest first:
  - mem_busy (hold): all enables 0, no flush/bubble, pc_sel_branch 0.
  - ex_branch_taken (flush): pc_en=1, pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1, other enables 1. A flush overrides a simultaneous load-use stall, because the ID instruction is squashed.
  - Load-use (stall): pc_en=0, if_id_en=0, id_ex_bubble=1, downstream enables 1. Exactly one bubble per load.
  - Otherwise: all enables 1, no flush/bubble.
- Forwarding: fwd_a=10 if mem_reg_write & mem_rd≠0 & mem_rd==ex_rs1; else 01 if wb_reg_write & wb_rd≠0 & wb_rd==ex_rs1; else 00. EX/MEM has priority. fwd_b is identical using ex_rs2. Forwarding is independent of state.
- RUN→DRAIN when halt_req=1 and no hold. The drain counter loads 0.
- DRAIN:
  - pc_en=0, if_id_flush=1, downstream enables 1.
  - Counter increments each non-hold cycle. At count==DRAIN_CYCLES-1 the next state is HALTED.
  - mem_busy freezes everything, including the counter.
  - ex_branch_taken in DRAIN: pc_en=1 and pc_sel_branch=1 for that cycle, so the target is held for resume.
  - Load-use in DRAIN: ignored, because the ID slot is flushed.
- HALTED: pc_en=0, all stage enables 0, halt_ack=1. When halt_req=0, the next state is RUN.
- halt_req dropping during DRAIN: the drain completes, passes through HALTED for one cycle, then returns to RUN.
- Asynchronous reset mid-operation: state returns to RUN and the counters clear immediately.

## Timing
- Reset values: state RUN, drain counter 0, halt_ack 0, counters 0. With all inputs 0: pc_en, all stage enables 1; pc_sel_branch, if_id_flush, id_ex_bubble 0; fwd_a, fwd_b 00.
- Stall, flush and hold controls act in the same cycle as the causing inputs (zero latency). Their effect appears at the next clk edge.
- The halt sequence from the first halt_req cycle (no holds) is 1 + DRAIN_CYCLES cycles: DRAIN for DRAIN_CYCLES cycles, then halt_ack=1 in the next cycle.
- Resume: halt_ack falls and pc_en rises one cycle after halt_req=0 is sampled in HALTED.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on each load-use stall cycle.
  - flush_cnt increments on each branch flush cycle.
  - hold_cnt increments on each mem_busy cycle.
  - All three are 16-bit, saturate at 0xFFFF and clear on reset.
- Undefined: counter logic is omitted, ports remain and are tied to 0.

## Test plan
- Load to x5 in EX, ID reads rs1=x5 -> one cycle with pc_en=0, if_id_en=0, id_ex_bubble=1; next cycle fwd_a=10; stall_cnt=1.
- Load to x0 in EX, ID reads x0 -> no stall; fwd_a=00.
- ex_branch_taken with a simultaneous load-use -> pc_sel_branch=1, if_id_flush=1, id_ex_bubble=1, pc_en=1; flush_cnt=1, stall_cnt unchanged.
- mem_rd=wb_rd=x7, both writing, ex_rs2=x7 -> fwd_b=10; with mem_reg_write=0 -> fwd_b=01.
- halt_req=1 with DRAIN_CYCLES=4 and mem_busy for 2 cycles mid-drain -> halt_ack rises 7 cycles after the request; halt_req=0 -> pc_en=1 one cycle later.
- Reset asserted during DRAIN -> state RUN, halt_ack 0, counters 0 asynchronously; with HAZARD_PERF_CNT_EN, 70000 forced stall cycles -> stall_cnt=0xFFFF.
